// File: rtl/sseg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sseg_pkg : shared constants and types for the display feeder       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sseg_pkg;

    localparam logic [31:0] c_addr_data = 32'h1100_00C0;
    localparam logic [31:0] c_addr_ctrl = 32'h1100_00C4;

    localparam int c_mode_bit  = 0;
    localparam int c_flush_bit = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sseg_io_ctrl_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : 2-flop synchroniser, debouncer and rise pulse       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module btn_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise
);

    localparam int                  c_cnt_w    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // High during the cycle whose edge promotes a press into the stable value
    assign o_rise   = r_sync2 & ~r_stable & (r_cnt == c_cnt_last);
    assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/sseg_io_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sseg_io_ctrl : IOBUS-mapped, rate-limited feeder for a 7-seg driver|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sseg_io_ctrl
    import sseg_pkg::*;
#(
    parameter logic [31:0] ADDR_DATA   = c_addr_data,
    parameter logic [31:0] ADDR_CTRL   = c_addr_ctrl,
    parameter int          HOLD_CYCLES = 5_000_000,
    parameter int          DB_CYCLES   = 500_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    input  logic        BTN_MODE,
    output logic [31:0] IOBUS_IN,
    output logic [15:0] DISP_DATA,
    output logic        DISP_MODE,
    output logic        HOLD_ACTIVE
);

    localparam int                   c_hold_w      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0]  c_hold_reload = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0]  c_hold_one    = c_hold_w'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_hold_w-1:0] w_hold_cnt_nxt;
    logic [15:0]         r_disp_data;
    logic [15:0]         w_disp_data_nxt;
    logic [15:0]         r_pend;
    logic [15:0]         w_pend_nxt;
    logic                r_pend_valid;
    logic                w_pend_valid_nxt;
    logic                r_disp_mode;

    logic w_wr_data;
    logic w_wr_ctrl;
    logic w_flush;
    logic w_btn_rise;
    logic w_btn_stable;
    logic w_unused;

    assign w_wr_data = IOBUS_WR && (IOBUS_ADDR == ADDR_DATA);
    assign w_wr_ctrl = IOBUS_WR && (IOBUS_ADDR == ADDR_CTRL);
    assign w_flush   = w_wr_ctrl && IOBUS_OUT[c_flush_bit];
    assign w_unused  = ^{IOBUS_OUT[31:16], w_btn_stable};

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk      (CLK),
        .rst_n    (RST_N),
        .i_btn    (BTN_MODE),
        .o_stable (w_btn_stable),
        .o_rise   (w_btn_rise)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_disp_data  <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_disp_mode  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_disp_data  <= w_disp_data_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            // An explicit mode write overrides a coincident button toggle
            if (w_wr_ctrl) begin
                r_disp_mode <= IOBUS_OUT[c_mode_bit];
            end else if (w_btn_rise) begin
                r_disp_mode <= ~r_disp_mode;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_disp_data_nxt  = r_disp_data;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_data) begin
                    w_disp_data_nxt = IOBUS_OUT[15:0];
                    w_hold_cnt_nxt  = c_hold_reload;
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt != '0) begin
                    w_hold_cnt_nxt = r_hold_cnt - c_hold_one;
                    if (w_wr_data) begin
                        w_pend_nxt       = IOBUS_OUT[15:0];
                        w_pend_valid_nxt = 1'b1;
                    end else if (w_flush && r_pend_valid) begin
                        w_disp_data_nxt  = r_pend;
                        w_pend_valid_nxt = 1'b0;
                        w_hold_cnt_nxt   = c_hold_reload;
                    end
                end else if (w_wr_data) begin
                    w_disp_data_nxt  = IOBUS_OUT[15:0];
                    w_pend_valid_nxt = 1'b0;
                    w_hold_cnt_nxt   = c_hold_reload;
                end else if (r_pend_valid) begin
                    // Covers a flush landing on expiry: pending value loads once
                    w_disp_data_nxt  = r_pend;
                    w_pend_valid_nxt = 1'b0;
                    w_hold_cnt_nxt   = c_hold_reload;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        IOBUS_IN = '0;
        if (IOBUS_ADDR == ADDR_DATA) begin
            IOBUS_IN = {16'b0, r_disp_data};
        end else if (IOBUS_ADDR == ADDR_CTRL) begin
            IOBUS_IN = {29'b0, r_pend_valid, HOLD_ACTIVE, r_disp_mode};
        end
    end

    assign HOLD_ACTIVE = (r_state == ST_HOLD);
    assign DISP_DATA   = r_disp_data;
    assign DISP_MODE   = r_disp_mode;

endmodule
`default_nettype wire
